// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory stage issuing loads/stores to a single-port bus and producing one writeback per request.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word accesses trap instead of issuing a bus request).
module lsu_mem_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       store_data,
   input  logic [4:0]        rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              wb_err
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic        ld_q;
   logic [2:0]  f3_q;
   logic [1:0]  a_q;
   logic [1:0]  a;
   logic        mem_op;
   logic        sz_b;
   logic        sz_h;
   logic        misalign;
   logic [3:0]  strb;
   logic [31:0] wdata;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ld_val;

   assign req_ready = (state == IDLE) && !rst;

   // Decode the incoming access size, store lanes and the load value from the bus.
   always_comb begin
      a      = alu_result[1:0];
      mem_op = is_load | is_store;
      sz_b   = (funct3[1:0] == 2'b00) && (is_load || !funct3[2]);
      sz_h   = (funct3[1:0] == 2'b01) && (is_load || !funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = mem_op && ((sz_h && a[0]) || (!sz_b && !sz_h && a != 2'b00));
`else
      misalign = 1'b0;
`endif
      strb   = sz_b ? 4'b0001 << a : sz_h ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
      wdata  = sz_b ? {4{store_data[7:0]}} : sz_h ? {2{store_data[15:0]}} : store_data;
      byte_v = mem_rdata[{a_q, 3'b000} +: 8];
      half_v = mem_rdata[{a_q[1], 4'b0000} +: 16];
      ld_val = f3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
               f3_q == 3'b100 ? {24'b0, byte_v} :
               f3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
               f3_q == 3'b101 ? {16'b0, half_v} : mem_rdata;
   end

   // Request acceptance, bus transaction tracking and writeback generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ld_q      <= 1'b0;
         f3_q      <= 3'b0;
         a_q       <= 2'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= 4'b0;
         mem_wdata <= 32'b0;
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         wb_rd     <= 5'b0;
         wb_data   <= 32'b0;
         wb_err    <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_err   <= 1'b0;
         if (state == IDLE && req_valid) begin
            wb_rd <= rd;
            if (mem_op && !misalign) begin
               state     <= REQ;
               mem_req   <= 1'b1;
               mem_we    <= !is_load;
               mem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
               mem_wstrb <= is_load ? 4'b0 : strb;
               mem_wdata <= is_load ? 32'b0 : wdata;
               ld_q      <= is_load;
               f3_q      <= funct3;
               a_q       <= a;
            end else begin
               state    <= DONE;
               wb_valid <= 1'b1;
               wb_we    <= !misalign && rd != 5'd0;
               wb_err   <= misalign;
               wb_data  <= alu_result;
            end
         end else if (state == REQ && mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= ld_q && wb_rd != 5'd0;
            wb_data  <= ld_q ? ld_val : 32'b0;
         end else if (state != REQ) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized checks of lsu_mem_stage against a behavioural model.
module tb_lsu_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        rdy;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        stable;
      logic        busy;
      logic        wv;
      logic        wwe;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        werr;
      logic        tail;
   } obs_t;

   lsu_mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .is_load(is_load), .is_store(is_store), .funct3(funct3), .alu_result(alu_result),
      .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   function automatic int acc_size(input logic ld, input logic [2:0] f3);
      if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
      if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
      return 4;
   endfunction

   function automatic logic misal(input int sz, input int a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (sz == 2 && a % 2 == 1) || (sz == 4 && a != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input int a, input logic [31:0] d);
      int sz = acc_size(1'b1, f3);
      logic sgn = (f3 == 3'd0 || f3 == 3'd1);
      logic [31:0] v;
      if (sz == 1) begin
         v = (d >> (8 * a)) & 32'hFF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = (d >> (16 * (a / 2))) & 32'hFFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else v = d;
      return v;
   endfunction

   function automatic obs_t model(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] alu,
                                  input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdata);
      obs_t e = '0;
      int a = int'(alu[1:0]);
      int sz = acc_size(ld, f3);
      logic mis = (ld || st) && misal(sz, a);
      e.rdy = 1'b1; e.stable = 1'b1; e.busy = 1'b1; e.tail = 1'b1; e.wv = 1'b1; e.wrd = r;
      if (!(ld || st) || mis) begin
         e.wwe = !mis && r != 0;
         e.wd = alu;
         e.werr = mis;
      end else begin
         e.req = 1'b1;
         e.we = !ld;
         e.addr = {alu[31:2], 2'b00};
         e.strb = sz == 1 ? 4'(1 << a) : sz == 2 ? 4'(3 << (2 * (a / 2))) : 4'hF;
         e.wdata = sz == 1 ? {24'b0, sd[7:0]} * 32'h0101_0101 : sz == 2 ? {16'b0, sd[15:0]} * 32'h0001_0001 : sd;
         e.wwe = ld && r != 0;
         e.wd = ld ? ld_model(f3, a, rdata) : 32'b0;
      end
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] r, input int dly, input logic [31:0] rdata,
                          output obs_t o);
      o = '0;
      is_load = ld; is_store = st; funct3 = f3; alu_result = alu; store_data = sd; rd = r; req_valid = 1'b1;
      o.rdy = req_ready;
      tick;
      req_valid = 1'b0;
      alu_result = $urandom; store_data = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);
      is_load = 1'($urandom); is_store = 1'($urandom);
      o.req = mem_req; o.we = mem_we; o.addr = mem_addr; o.strb = mem_wstrb; o.wdata = mem_wdata;
      o.stable = 1'b1; o.busy = 1'b1;
      if (mem_req === 1'b1) begin
         for (int i = 0; i <= dly; i++) begin
            if (mem_req !== 1'b1 || mem_we !== o.we || mem_addr !== o.addr || mem_wstrb !== o.strb ||
                mem_wdata !== o.wdata || wb_valid !== 1'b0) o.stable = 1'b0;
            if (req_ready !== 1'b0) o.busy = 1'b0;
            if (i == dly) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
            end
            tick;
         end
         mem_ack = 1'b0;
         mem_rdata = $urandom;
      end
      if (mem_req !== 1'b0) o.stable = 1'b0;
      o.wv = wb_valid; o.wwe = wb_we; o.wrd = wb_rd; o.wd = wb_data; o.werr = wb_err;
      tick;
      o.tail = wb_valid === 1'b0 && req_ready === 1'b1 && mem_req === 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
      n_cmp++; if ({mem_req, mem_we, mem_wstrb, wb_valid, wb_we, wb_err} !== 9'b0) begin
         n_bad++; $display("FAIL rst_ctl got %b want 0", {mem_req, mem_we, mem_wstrb, wb_valid, wb_we, wb_err});
      end
      n_cmp++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== 101'b0) begin
         n_bad++; $display("FAIL rst_data got %h/%h/%h/%h want 0", mem_addr, mem_wdata, wb_data, wb_rd);
      end
      rst = 1'b0;
      tick;
      n_cmp++; if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
         n_bad++; $display("FAIL post_rst got ready=%b wbv=%b want 1/0", req_ready, wb_valid);
      end
   endtask

   task automatic test_passthrough;
      obs_t o;
      run_txn(1'b0, 1'b0, 3'd2, 32'h0000_1234, 32'hFFFF_FFFF, 5'd5, 0, 32'h0, o);
      n_cmp++; if (o.rdy !== 1'b1 || o.req !== 1'b0) begin n_bad++; $display("FAIL pass_hs got rdy=%b req=%b want 1/0", o.rdy, o.req); end
      n_cmp++; if (o.wv !== 1'b1 || o.wd !== 32'h0000_1234) begin n_bad++; $display("FAIL pass_wb got v=%b d=%h want 1/00001234", o.wv, o.wd); end
      n_cmp++; if (o.wwe !== 1'b1 || o.wrd !== 5'd5 || o.werr !== 1'b0) begin n_bad++; $display("FAIL pass_rd got we=%b rd=%0d err=%b want 1/5/0", o.wwe, o.wrd, o.werr); end
      n_cmp++; if (o.tail !== 1'b1) begin n_bad++; $display("FAIL pass_tail got %b want 1", o.tail); end
      run_txn(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd0, 0, 32'h0, o);
      n_cmp++; if (o.wv !== 1'b1 || o.wwe !== 1'b0) begin n_bad++; $display("FAIL pass_rd0 got v=%b we=%b want 1/0", o.wv, o.wwe); end
   endtask

   task automatic test_loads;
      obs_t o;
      run_txn(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd3, 0, 32'h80FF_0000, o);
      n_cmp++; if (o.req !== 1'b1 || o.we !== 1'b0 || o.addr !== 32'h100) begin n_bad++; $display("FAIL lb_bus got req=%b we=%b addr=%h want 1/0/100", o.req, o.we, o.addr); end
      n_cmp++; if (o.wv !== 1'b1 || o.wd !== 32'hFFFF_FF80 || o.wwe !== 1'b1) begin n_bad++; $display("FAIL lb_wb got v=%b d=%h we=%b want 1/ffffff80/1", o.wv, o.wd, o.wwe); end
      run_txn(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0, 5'd3, 0, 32'h80FF_0000, o);
      n_cmp++; if (o.wv !== 1'b1 || o.wd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_wb got v=%b d=%h want 1/00000080", o.wv, o.wd); end
      run_txn(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h80FF_0000, o);
      n_cmp++; if (o.wd !== 32'hFFFF_80FF) begin n_bad++; $display("FAIL lh_wb got %h want ffff80ff", o.wd); end
      run_txn(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h80FF_0000, o);
      n_cmp++; if (o.wd !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu_wb got %h want 000080ff", o.wd); end
      run_txn(1'b1, 1'b1, 3'd2, 32'h0000_0300, 32'h1111_1111, 5'd6, 0, 32'hCAFE_F00D, o);
      n_cmp++; if (o.we !== 1'b0 || o.wd !== 32'hCAFE_F00D || o.wwe !== 1'b1) begin n_bad++; $display("FAIL ldst_both got we=%b d=%h wwe=%b want 0/cafef00d/1", o.we, o.wd, o.wwe); end
   endtask

   task automatic test_stores;
      obs_t o;
      run_txn(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd7, 0, 32'h0, o);
      n_cmp++; if (o.req !== 1'b1 || o.we !== 1'b1 || o.addr !== 32'h200) begin n_bad++; $display("FAIL sh_bus got req=%b we=%b addr=%h want 1/1/200", o.req, o.we, o.addr); end
      n_cmp++; if (o.strb !== 4'b1100 || o.wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_lane got strb=%b wdata=%h want 1100/abcdabcd", o.strb, o.wdata); end
      n_cmp++; if (o.wv !== 1'b1 || o.wwe !== 1'b0 || o.wd !== 32'h0) begin n_bad++; $display("FAIL sh_wb got v=%b we=%b d=%h want 1/0/0", o.wv, o.wwe, o.wd); end
      run_txn(1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'h0000_0055, 5'd7, 1, 32'h0, o);
      n_cmp++; if (o.strb !== 4'b0010 || o.wdata !== 32'h5555_5555) begin n_bad++; $display("FAIL sb_lane got strb=%b wdata=%h want 0010/55555555", o.strb, o.wdata); end
   endtask

   task automatic test_delayed_ack;
      obs_t o;
      run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd8, 3, 32'hDEAD_BEEF, o);
      n_cmp++; if (o.stable !== 1'b1 || o.busy !== 1'b1 || o.addr !== 32'h40) begin n_bad++; $display("FAIL lw_hold got stable=%b busy=%b addr=%h want 1/1/40", o.stable, o.busy, o.addr); end
      n_cmp++; if (o.wv !== 1'b1 || o.wd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_wb got v=%b d=%h want 1/deadbeef", o.wv, o.wd); end
      mem_ack = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick;
      mem_ack = 1'b0;
      n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL spur_ack got wbv=%b req=%b rdy=%b want 0/0/1", wb_valid, mem_req, req_ready); end
      tick;
      n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL spur_ack2 got wbv=%b want 0", wb_valid); end
   endtask

   task automatic test_misalign;
      obs_t o;
      run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 5'd9, 0, 32'h1122_3344, o);
`ifdef LSU_MISALIGN_TRAP_EN
      n_cmp++; if (o.req !== 1'b0) begin n_bad++; $display("FAIL mis_req got %b want 0", o.req); end
      n_cmp++; if (o.wv !== 1'b1 || o.werr !== 1'b1 || o.wwe !== 1'b0 || o.wd !== 32'h101) begin
         n_bad++; $display("FAIL mis_wb got v=%b err=%b we=%b d=%h want 1/1/0/101", o.wv, o.werr, o.wwe, o.wd);
      end
`else
      n_cmp++; if (o.req !== 1'b1 || o.addr !== 32'h100) begin n_bad++; $display("FAIL mis_bus got req=%b addr=%h want 1/100", o.req, o.addr); end
      n_cmp++; if (o.wv !== 1'b1 || o.werr !== 1'b0 || o.wd !== 32'h1122_3344) begin
         n_bad++; $display("FAIL mis_wb got v=%b err=%b d=%h want 1/0/11223344", o.wv, o.werr, o.wd);
      end
`endif
   endtask

   task automatic test_reset_mid;
      obs_t o;
      is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; alu_result = 32'h0000_0080; rd = 5'd10; req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req got %b want 1", mem_req); end
      tick;
      rst = 1'b1;
      tick;
      n_cmp++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_rst got req=%b wbv=%b rdy=%b want 0/0/0", mem_req, wb_valid, req_ready); end
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hAAAA_5555;
      tick;
      mem_ack = 1'b0;
      n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ack got wbv=%b req=%b rdy=%b want 0/0/1", wb_valid, mem_req, req_ready); end
      run_txn(1'b0, 1'b0, 3'd0, 32'h0000_0777, 32'h0, 5'd11, 0, 32'h0, o);
      n_cmp++; if (o.rdy !== 1'b1 || o.wv !== 1'b1 || o.wd !== 32'h777) begin n_bad++; $display("FAIL rmid_new got rdy=%b v=%b d=%h want 1/1/777", o.rdy, o.wv, o.wd); end
   endtask

   task automatic test_random;
      obs_t o;
      obs_t e;
      for (int k = 0; k < 80; k++) begin
         int kind = $urandom_range(0, 3);
         logic ld = kind == 1 || kind == 3;
         logic st = kind == 2 || kind == 3;
         logic [2:0] f3 = 3'($urandom_range(0, 7));
         logic [31:0] alu = $urandom;
         logic [31:0] sd = $urandom;
         logic [4:0] r = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
         int dly = $urandom_range(0, 3);
         logic [31:0] rdata = $urandom;
         e = model(ld, st, f3, alu, sd, r, rdata);
         run_txn(ld, st, f3, alu, sd, r, dly, rdata, o);
         n_cmp++; if (o.rdy !== e.rdy || o.req !== e.req) begin n_bad++; $display("FAIL rnd%0d hs got rdy=%b req=%b want %b/%b", k, o.rdy, o.req, e.rdy, e.req); end
         if (e.req) begin
            n_cmp++; if (o.we !== e.we || o.addr !== e.addr) begin n_bad++; $display("FAIL rnd%0d bus got we=%b addr=%h want %b/%h", k, o.we, o.addr, e.we, e.addr); end
            n_cmp++; if (o.stable !== 1'b1 || o.busy !== 1'b1) begin n_bad++; $display("FAIL rnd%0d hold got stable=%b busy=%b want 1/1", k, o.stable, o.busy); end
            if (e.we) begin
               n_cmp++; if (o.strb !== e.strb || o.wdata !== e.wdata) begin n_bad++; $display("FAIL rnd%0d lane got strb=%b wdata=%h want %b/%h", k, o.strb, o.wdata, e.strb, e.wdata); end
            end
         end
         n_cmp++; if (o.wv !== e.wv || o.wwe !== e.wwe || o.werr !== e.werr) begin n_bad++; $display("FAIL rnd%0d wbctl got v=%b we=%b err=%b want %b/%b/%b", k, o.wv, o.wwe, o.werr, e.wv, e.wwe, e.werr); end
         n_cmp++; if (o.wd !== e.wd) begin n_bad++; $display("FAIL rnd%0d wbdata got %h want %h", k, o.wd, e.wd); end
         if (!(e.req && e.we)) begin
            n_cmp++; if (o.wrd !== e.wrd) begin n_bad++; $display("FAIL rnd%0d wbrd got %0d want %0d", k, o.wrd, e.wrd); end
         end
         n_cmp++; if (o.tail !== e.tail) begin n_bad++; $display("FAIL rnd%0d tail got %b want %b", k, o.tail, e.tail); end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
      alu_result = 32'h0; store_data = 32'h0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
      test_reset;
      test_passthrough;
      test_loads;
      test_stores;
      test_delayed_ack;
      test_misalign;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory stage directly downstream of the ALU: takes the ALU result as an effective address or pass-through value, runs loads and stores against a single-port data-memory bus, and produces one writeback beat per accepted request.
- Handles byte, halfword and word accesses: byte-lane strobes, store-data replication, and load sign/zero extension.
- Non-memory instructions pass through to writeback with fixed 1-cycle latency.

Parameters:
- ADDR_W, 32, width of mem_addr; the upper bits of the ALU result are dropped.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request from execute
- req_ready  out  1  stage can accept a request this cycle
- is_load  in  1  request is a load
- is_store  in  1  request is a store
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result  in  32  effective address (load/store) or result (other)
- store_data  in  32  rs2 value for stores
- rd  in  5  destination register
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0
- mem_wstrb  out  4  byte-lane write enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  32  read data, valid when mem_ack=1
- wb_valid  out  1  1-cycle writeback pulse
- wb_we  out  1  register write enable (0 for stores and for rd=0)
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- wb_err  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0 and state = IDLE, except req_ready, which is 1 on the cycle after rst deasserts.
- States: IDLE, REQ, DONE.
- Handshake: a request is accepted on an edge where req_valid && req_ready. req_ready = (state == IDLE). There is no writeback backpressure.
- Accept with neither is_load nor is_store:
  - state -> DONE.
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_we=(rd!=0).
  - Latency is 1 cycle.
- Accept with is_load or is_store:
  - Register address, size and data; state -> REQ.
  - On the next cycle mem_req=1.
- If is_load and is_store are both set, the request is a load.
- In REQ:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until the mem_ack cycle.
  - On the mem_ack edge: mem_req -> 0, state -> DONE, load data is captured.
  - Minimum load/store latency is accept + 2 cycles (ack on the first REQ cycle).
- DONE lasts one cycle: wb_valid=1, then state -> IDLE.
  - For stores: wb_we=0, wb_data=0.
  - For loads: wb_we=(rd!=0).
- Store lanes (a = alu_result[1:0]):
  - SB: wstrb = 4'b0001 << a; wdata = {4{store_data[7:0]}}.
  - SH: wstrb = 4'b0011 << {a[1],1'b0}; wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = store_data.
  - Store funct3 values other than 000/001/010 are treated as SW.
- Load extraction:
  - Byte = mem_rdata[8a+7:8a].
  - Half = mem_rdata[16a[1]+15:16a[1]].
  - B/H are sign-extended; BU/HU are zero-extended; W is taken as-is.
  - Load funct3 values 011/110/111 are treated as LW.
- mem_ack outside REQ (late or spurious) is ignored and has no effect.
- Reset mid-operation: on the rst edge, state -> IDLE and mem_req -> 0. The pending transaction is abandoned, no writeback is produced, and a subsequent ack is ignored.
- mem_rdata is sampled only on the mem_ack cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with a[0]=1, or a word access with a!=0, issues no mem_req.
  - The stage goes IDLE -> DONE; the next cycle gives wb_valid=1, wb_err=1, wb_we=0, wb_data=alu_result (faulting address).
  - Latency is 1 cycle.
- Not defined:
  - wb_err is tied 0.
  - The misaligned low address bits are ignored: a halfword uses a[1] only, a word uses lane 0.
  - mem_addr = {alu_result[ADDR_W-1:2],2'b00} in both builds.

Test Plan:
- Pass-through: accept alu_result=0x00001234, rd=5, no ld/st -> next cycle wb_valid=1, wb_data=0x00001234, wb_we=1, no mem_req; with rd=0, wb_we=0.
- Loads at 0x103, ack on the first REQ cycle, mem_rdata=0x80FF0000:
  - LB -> wb_data=0xFFFFFF80.
  - LBU -> wb_data=0x00000080.
  - Both arrive on cycle accept+2.
- SH at 0x202, store_data=0x1234ABCD -> mem_addr=0x200, mem_we=1, wstrb=4'b1100, wdata=0xABCDABCD; after ack, wb_valid=1, wb_we=0.
- LW at 0x40 with ack delayed 3 cycles:
  - mem_req and mem_addr stay stable for all 3 cycles; req_ready=0 throughout.
  - wb_valid comes 1 cycle after ack with wb_data=mem_rdata.
  - A spurious ack in IDLE changes nothing.
- LW at 0x101:
  - With LSU_MISALIGN_TRAP_EN: no mem_req; wb_err=1, wb_data=0x00000101.
  - Without it: mem_addr=0x100, wstrb irrelevant, wb_err=0.
- rst asserted while in REQ:
  - Next edge: mem_req=0, wb_valid=0, state IDLE.
  - An ack arriving afterwards produces no wb_valid.
  - A new request is accepted on the cycle after rst deasserts.
